urv_console_uart: RTL and testbench

Memory-mapped console transmitter on the uRV data-memory bus. Sits directly downstream of the CPU data port at the console address and replaces the simulation-only "store to 0x100000 prints a character" path with real hardware. Bytes pass through a small FIFO and are serialized as 8N1 on `txd_o`. Stores stall via `dm_store_done_o` while the FIFO is full.

---
 rtl/urv_console_pkg.sv | 35 +++
 rtl/urv_sync_fifo.sv | 58 +++++
 rtl/urv_console_uart.sv | 168 ++++++++++++++++
 tb/tb_urv_console_uart.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_console_pkg.sv
// Shared definitions for the uRV console: register offsets, STATUS layout
// and the transmitter state encoding.
package urv_console_pkg;

   // Register offsets relative to the console base address
   localparam logic [31:0] CONSOLE_REG_TXDATA = 32'd0;
   localparam logic [31:0] CONSOLE_REG_STATUS = 32'd4;

   // STATUS register bit positions
   localparam int STATUS_FULL_BIT  = 0;
   localparam int STATUS_BUSY_BIT  = 1;
   localparam int STATUS_LEVEL_LSB = 8;
   localparam int STATUS_LEVEL_MSB = 15;

   // Transmitter frame phases
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // Assemble the STATUS word; every bit not named here reads as zero
   function automatic logic [31:0] pack_status(input logic full,
                                               input logic busy,
                                               input logic [7:0] level);
      logic [31:0] s;
      s = 32'd0;
      s[STATUS_FULL_BIT] = full;
      s[STATUS_BUSY_BIT] = busy;
      s[STATUS_LEVEL_MSB:STATUS_LEVEL_LSB] = level;
      return s;
   endfunction

endpackage

// File: rtl/urv_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. The wrap bit distinguishes
// full from empty when the index bits match. Written to be reused by a
// future receive path.
module urv_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer bookkeeping; both pointers simply wrap through the extra MSB
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/urv_console_uart.sv
// Memory-mapped console transmitter on the uRV data bus. Stores to TXDATA
// queue a byte in the TX FIFO, which the FSM serializes as 8N1 on txd_o.
// Stores stall (no acknowledge) while the FIFO is full.
module urv_console_uart
   import urv_console_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
   parameter int          CLK_DIV    = 868,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_store_i,
   input  logic        dm_load_i,
   output logic [31:0] dm_data_l_o,
   output logic        dm_store_done_o,
   output logic        dm_load_done_o,
   output logic        txd_o
);

   localparam int              CW          = $clog2(CLK_DIV);
   localparam int              LW          = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]   BAUD_RELOAD = CW'(CLK_DIV - 1);
   localparam logic [29:0]     TXDATA_WORD = 30'((BASE_ADDR + CONSOLE_REG_TXDATA) >> 2);
   localparam logic [29:0]     STATUS_WORD = 30'((BASE_ADDR + CONSOLE_REG_STATUS) >> 2);

   logic            hit_txdata;
   logic            hit_status;
   logic            store_txdata;
   logic            store_status;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [7:0]      fifo_rd_data;
   logic [LW-1:0]   fifo_level;
   logic [7:0]      level_byte;
   logic            busy;
   logic [31:0]     status_word;

   tx_state_t       state;
   logic [7:0]      shift_reg;
   logic [2:0]      bit_cnt;
   logic [CW-1:0]   baud_cnt;
   logic            bit_end;

   // Bits of the bus that the console never looks at
   logic            unused_bus_bits;
   assign unused_bus_bits = ^{dm_data_s_i[31:8], dm_data_select_i[3:1], dm_addr_i[1:0]};

   // Word-granular decode of the two console registers
   assign hit_txdata = (dm_addr_i[31:2] == TXDATA_WORD);
   assign hit_status = (dm_addr_i[31:2] == STATUS_WORD);

   // A held store is only taken once; the done flag blocks re-acceptance
   // in the acknowledge cycle, and a full FIFO holds TXDATA stores off
   assign store_txdata = dm_store_i && hit_txdata && !fifo_full && !dm_store_done_o;
   assign store_status = dm_store_i && hit_status && !dm_store_done_o;
   assign push         = store_txdata && dm_data_select_i[0];

   // The FSM pulls the next byte when idle or at the end of a stop bit
   assign bit_end = (baud_cnt == '0);
   assign pop     = !fifo_empty &&
                    ((state == TX_IDLE) || ((state == TX_STOP) && bit_end));

   assign busy        = (state != TX_IDLE) || !fifo_empty;
   assign level_byte  = 8'(fifo_level);
   assign status_word = pack_status(fifo_full, busy, level_byte);

   urv_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .push    (push),
      .pop     (pop),
      .wr_data (dm_data_s_i[7:0]),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Bus acknowledges and load data, one cycle after the request is taken
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dm_store_done_o <= 1'b0;
         dm_load_done_o  <= 1'b0;
         dm_data_l_o     <= 32'd0;
      end else begin
         dm_store_done_o <= store_txdata || store_status;
         dm_load_done_o  <= dm_load_i && (hit_txdata || hit_status);
         dm_data_l_o     <= (dm_load_i && hit_status) ? status_word : 32'd0;
      end
   end

   // Transmit FSM with baud timing; txd_o is registered from the current
   // phase, so the line follows the state by one cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= TX_IDLE;
         shift_reg <= 8'd0;
         bit_cnt   <= 3'd0;
         baud_cnt  <= '0;
         txd_o     <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               txd_o <= 1'b1;
               if (!fifo_empty) begin
                  shift_reg <= fifo_rd_data;
                  baud_cnt  <= BAUD_RELOAD;
                  bit_cnt   <= 3'd0;
                  state     <= TX_START;
               end
            end
            TX_START: begin
               txd_o <= 1'b0;
               if (bit_end) begin
                  baud_cnt <= BAUD_RELOAD;
                  bit_cnt  <= 3'd0;
                  state    <= TX_DATA;
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            TX_DATA: begin
               txd_o <= shift_reg[0];
               if (bit_end) begin
                  baud_cnt  <= BAUD_RELOAD;
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  if (bit_cnt == 3'd7) begin
                     state <= TX_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            TX_STOP: begin
               txd_o <= 1'b1;
               if (bit_end) begin
                  if (!fifo_empty) begin
                     shift_reg <= fifo_rd_data;
                     baud_cnt  <= BAUD_RELOAD;
                     bit_cnt   <= 3'd0;
                     state     <= TX_START;
                  end else begin
                     state <= TX_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            default: begin
               txd_o <= 1'b1;
               state <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_urv_console_uart.sv
// Scoreboard bench for urv_console_uart with CLK_DIV=4, FIFO_DEPTH=4.
// Drivers push expected loads, acknowledges and serial bytes into queues;
// independent monitors pop and compare whenever the DUT produces them.
module tb_urv_console_uart;

   localparam int          DIV   = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0010_0000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] dm_addr_i = 32'd0;
   logic [31:0] dm_data_s_i = 32'd0;
   logic [3:0]  dm_data_select_i = 4'd0;
   logic        dm_store_i = 1'b0;
   logic        dm_load_i = 1'b0;
   logic [31:0] dm_data_l_o;
   logic        dm_store_done_o;
   logic        dm_load_done_o;
   logic        txd_o;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [7:0]  exp_bytes[$];
   logic [31:0] exp_load[$];
   int          exp_ack[$];
   int          start_q[$];

   int store_id = 0;
   int active_id = -1;

   bit         mon_in_frame = 1'b0;
   int         mon_pos = 0;
   bit         mon_glitch = 1'b0;
   logic [7:0] mon_byte = 8'd0;
   logic       prev_done = 1'b0;

   urv_console_uart #(
      .BASE_ADDR  (BASE),
      .CLK_DIV    (DIV),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .dm_addr_i        (dm_addr_i),
      .dm_data_s_i      (dm_data_s_i),
      .dm_data_select_i (dm_data_select_i),
      .dm_store_i       (dm_store_i),
      .dm_load_i        (dm_load_i),
      .dm_data_l_o      (dm_data_l_o),
      .dm_store_done_o  (dm_store_done_o),
      .dm_load_done_o   (dm_load_done_o),
      .txd_o            (txd_o)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   // Edge counter used to relate acknowledges and frame starts
   always @(posedge clk_i) cyc <= cyc + 1;

   // Single comparison point shared by every checker
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at cycle %0d",
                  name, actual, required, cyc);
      end
   endtask

   // Bus driver: one store (held until acknowledged) or one single-cycle load
   task automatic applyStimulus(input bit is_load, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] sel,
                                input bit expect_ack, input logic [31:0] exp_data,
                                output int ack_cyc);
      int waited;
      ack_cyc = -1;
      @(negedge clk_i);
      dm_addr_i = addr;
      dm_data_s_i = data;
      dm_data_select_i = sel;
      if (is_load) begin
         exp_load.push_back(exp_data);
         dm_load_i = 1'b1;
         @(negedge clk_i);
         dm_load_i = 1'b0;
         repeat (2) @(posedge clk_i);
         #2;
         checkOutput("load_ack", exp_load.size(), 0);
         exp_load.delete();
      end else begin
         store_id++;
         active_id = store_id;
         if (expect_ack) exp_ack.push_back(store_id);
         dm_store_i = 1'b1;
         waited = 0;
         while (1) begin
            @(posedge clk_i);
            #2;
            waited++;
            if (dm_store_done_o) begin
               ack_cyc = cyc;
               break;
            end
            if (!expect_ack && waited >= 10) break;
            if (waited >= 300) break;
         end
         if (expect_ack) checkOutput("store_ack", (ack_cyc >= 0), 1);
         else            checkOutput("store_no_ack", (ack_cyc >= 0), 0);
         @(negedge clk_i);
         dm_store_i = 1'b0;
         active_id = -1;
         exp_ack.delete();
      end
   endtask

   // Wait (bounded) until every expected frame has appeared on the line
   task automatic waitDrain();
      int n = 0;
      while ((exp_bytes.size() != 0 || mon_in_frame) && n < 3000) begin
         @(posedge clk_i);
         #2;
         n++;
      end
      repeat (4) @(posedge clk_i);
      #2;
      checkOutput("drain", exp_bytes.size(), 0);
   endtask

   // Load monitor: every load acknowledge must match the next expected word
   initial begin
      logic [31:0] e;
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_i && dm_load_done_o) begin
            checkOutput("load_expected", (exp_load.size() != 0), 1);
            if (exp_load.size() != 0) begin
               e = exp_load.pop_front();
               checkOutput("load_data", dm_data_l_o, e);
            end
         end
      end
   end

   // Acknowledge monitor: single-cycle pulses, only for the active store
   initial begin
      int id;
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_i) begin
            if (dm_store_done_o) begin
               checkOutput("ack_single_cycle", prev_done, 0);
               checkOutput("ack_expected", (exp_ack.size() != 0), 1);
               if (exp_ack.size() != 0) begin
                  id = exp_ack.pop_front();
                  checkOutput("ack_id", id, active_id);
               end
            end
            prev_done = dm_store_done_o;
         end else begin
            prev_done = 1'b0;
         end
      end
   end

   // Serial monitor: samples txd_o every cycle and rebuilds 8N1 frames
   initial begin
      int seg;
      int sub;
      logic [7:0] e;
      forever begin
         @(posedge clk_i);
         #1;
         if (rst_i) begin
            mon_in_frame = 1'b0;
         end else if (!mon_in_frame) begin
            if (txd_o === 1'b0) begin
               mon_in_frame = 1'b1;
               mon_pos = 1;
               mon_glitch = 1'b0;
               mon_byte = 8'd0;
               start_q.push_back(cyc);
            end
         end else begin
            seg = mon_pos / DIV;
            sub = mon_pos % DIV;
            if (seg == 0) begin
               if (txd_o !== 1'b0) mon_glitch = 1'b1;
            end else if (seg <= 8) begin
               if (sub == 0) mon_byte[seg-1] = txd_o;
               else if (txd_o !== mon_byte[seg-1]) mon_glitch = 1'b1;
            end else begin
               if (txd_o !== 1'b1) mon_glitch = 1'b1;
            end
            mon_pos++;
            if (mon_pos == 10*DIV) begin
               mon_in_frame = 1'b0;
               checkOutput("frame_expected", (exp_bytes.size() != 0), 1);
               if (exp_bytes.size() != 0) begin
                  e = exp_bytes.pop_front();
                  checkOutput("frame_byte", mon_byte, e);
               end
               checkOutput("frame_shape", mon_glitch, 0);
            end
         end
      end
   end

   // Hard stop in case something wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios
   initial begin
      int ack_cyc;
      int ack6;
      int n_starts;
      int n;

      // Reset values
      $display("[TB] reset values");
      repeat (3) begin
         @(posedge clk_i);
         #2;
         checkOutput("reset_txd", txd_o, 1);
      end
      checkOutput("reset_store_done", dm_store_done_o, 0);
      checkOutput("reset_load_done", dm_load_done_o, 0);
      checkOutput("reset_load_data", dm_data_l_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      applyStimulus(1'b1, BASE + 32'd4, 32'd0, 4'd0, 1'b1, 32'h0000_0000, ack_cyc);
      checkOutput("idle_txd", txd_o, 1);

      // Single byte 0x41
      $display("[TB] single byte");
      start_q.delete();
      exp_bytes.push_back(8'h41);
      applyStimulus(1'b0, BASE, 32'h0000_0041, 4'b0001, 1'b1, 32'd0, ack_cyc);
      waitDrain();
      checkOutput("t2_start_count", start_q.size(), 1);
      if (start_q.size() != 0) checkOutput("t2_fall_latency", start_q[0] - ack_cyc, 2);

      // Full-FIFO stall with bytes 1..6
      $display("[TB] full fifo stall");
      start_q.delete();
      for (int b = 1; b <= 5; b++) begin
         exp_bytes.push_back(8'(b));
         applyStimulus(1'b0, BASE, 32'(b), 4'b0001, 1'b1, 32'd0, ack_cyc);
      end
      applyStimulus(1'b1, BASE + 32'd4, 32'd0, 4'd0, 1'b1, 32'h0000_0403, ack_cyc);
      exp_bytes.push_back(8'd6);
      applyStimulus(1'b0, BASE, 32'd6, 4'b0001, 1'b1, 32'd0, ack6);
      checkOutput("t3_stall_starts", start_q.size(), 2);
      if (start_q.size() >= 2) checkOutput("t3_ack_after_pop", ack6, start_q[1]);
      waitDrain();
      checkOutput("t3_frame_count", start_q.size(), 6);
      if (start_q.size() == 6) begin
         for (int k = 0; k < 5; k++) begin
            checkOutput("t3_no_gap", start_q[k+1] - start_q[k], 10*DIV);
         end
      end

      // Status during the second frame with two bytes queued
      $display("[TB] status mid-transmission");
      start_q.delete();
      exp_bytes.push_back(8'hC3);
      exp_bytes.push_back(8'h5A);
      exp_bytes.push_back(8'h0F);
      exp_bytes.push_back(8'hF0);
      applyStimulus(1'b0, BASE, 32'h0000_00C3, 4'b0001, 1'b1, 32'd0, ack_cyc);
      applyStimulus(1'b0, BASE, 32'h0000_005A, 4'b0001, 1'b1, 32'd0, ack_cyc);
      applyStimulus(1'b0, BASE, 32'h0000_000F, 4'b0001, 1'b1, 32'd0, ack_cyc);
      applyStimulus(1'b0, BASE, 32'h0000_00F0, 4'b0001, 1'b1, 32'd0, ack_cyc);
      repeat (50) @(posedge clk_i);
      applyStimulus(1'b1, BASE + 32'd4, 32'd0, 4'd0, 1'b1, 32'h0000_0202, ack_cyc);
      waitDrain();

      // Non-decoded, lane-masked and STATUS stores
      $display("[TB] non-decoded and masked stores");
      start_q.delete();
      applyStimulus(1'b0, 32'h0010_0008, 32'h0000_0077, 4'b0001, 1'b0, 32'd0, ack_cyc);
      applyStimulus(1'b1, BASE + 32'd4, 32'd0, 4'd0, 1'b1, 32'h0000_0000, ack_cyc);
      applyStimulus(1'b0, BASE, 32'h0000_6600, 4'b0010, 1'b1, 32'd0, ack_cyc);
      applyStimulus(1'b0, BASE + 32'd4, 32'h0000_0055, 4'b0001, 1'b1, 32'd0, ack_cyc);
      applyStimulus(1'b1, BASE, 32'd0, 4'd0, 1'b1, 32'h0000_0000, ack_cyc);
      repeat (60) @(posedge clk_i);
      applyStimulus(1'b1, BASE + 32'd4, 32'd0, 4'd0, 1'b1, 32'h0000_0000, ack_cyc);
      checkOutput("t5_no_frames", start_q.size(), 0);

      // Reset during data bit 3 with two bytes queued
      $display("[TB] reset mid-frame");
      start_q.delete();
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back(8'h3C);
      exp_bytes.push_back(8'h7E);
      applyStimulus(1'b0, BASE, 32'h0000_00A5, 4'b0001, 1'b1, 32'd0, ack_cyc);
      applyStimulus(1'b0, BASE, 32'h0000_003C, 4'b0001, 1'b1, 32'd0, ack_cyc);
      applyStimulus(1'b0, BASE, 32'h0000_007E, 4'b0001, 1'b1, 32'd0, ack_cyc);
      n = 0;
      while (!(mon_in_frame && mon_pos == 18) && n < 500) begin
         @(posedge clk_i);
         #2;
         n++;
      end
      checkOutput("t6_reached_bit3", mon_pos, 18);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #2;
      checkOutput("t6_txd_after_reset", txd_o, 1);
      exp_bytes.delete();
      n_starts = start_q.size();
      @(negedge clk_i);
      rst_i = 1'b0;
      applyStimulus(1'b1, BASE + 32'd4, 32'd0, 4'd0, 1'b1, 32'h0000_0000, ack_cyc);
      repeat (100) begin
         @(posedge clk_i);
      end
      #2;
      checkOutput("t6_no_frames", start_q.size(), n_starts);
      checkOutput("t6_txd_idle", txd_o, 1);

      checkOutput("end_exp_bytes", exp_bytes.size(), 0);
      checkOutput("end_exp_load", exp_load.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
